// File: rtl/sr_pkg.sv
// Shared definitions for the SR latch driver: FSM state encoding and timer width.
package sr_pkg;

    localparam int SR_TIMER_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        DEAD  = 2'd2
    } sr_state_t;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down counter; expire flags the final cycle of a loaded interval.
module sr_pulse_timer
    import sr_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [SR_TIMER_W-1:0] load_val,
    output logic [SR_TIMER_W-1:0] value,
    output logic                  expire
);

    // Counter register: load wins, otherwise count down and hold at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= {SR_TIMER_W{1'b0}};
        end else if (load) begin
            value <= load_val;
        end else if (value != {SR_TIMER_W{1'b0}}) begin
            value <= value - {{(SR_TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            value <= value;
        end
    end

    assign expire = (value == {{(SR_TIMER_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/sr_latch_driver.sv
// Drives S/R of an asynchronous latch from valid/ready requests with fixed pulse
// and dead times, tracks the expected latch value and flags feedback mismatches.
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int PULSE_W = 4,
    parameter int DEAD_W  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic req_valid,
    input  logic req_val,
    output logic req_ready,
    input  logic q_fb,
    input  logic err_clr,
    output logic s_out,
    output logic r_out,
    output logic q_exp,
    output logic q_known,
    output logic err
);

    localparam logic [SR_TIMER_W-1:0] PULSE_LD = SR_TIMER_W'(PULSE_W);
    localparam logic [SR_TIMER_W-1:0] DEAD_LD  = SR_TIMER_W'(DEAD_W);

    sr_state_t             state_r;
    sr_state_t             next_state_s;
    logic                  req_val_r;
    logic                  accept_s;
    logic                  timer_load_s;
    logic [SR_TIMER_W-1:0] timer_load_val_s;
    logic [SR_TIMER_W-1:0] timer_value_s;
    logic                  timer_expire_s;
    logic                  pulse_done_r;
    logic                  dead_done_r;

    sr_pulse_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (timer_load_s),
        .load_val (timer_load_val_s),
        .value    (timer_value_s),
        .expire   (timer_expire_s)
    );

    // Next-state logic; a request already matching the known latch value is absorbed.
    always_comb begin
        next_state_s     = state_r;
        accept_s         = 1'b0;
        timer_load_s     = 1'b0;
        timer_load_val_s = {SR_TIMER_W{1'b0}};
        case (state_r)
            IDLE: begin
                if (req_valid && !(q_known && (req_val == q_exp))) begin
                    next_state_s     = PULSE;
                    accept_s         = 1'b1;
                    timer_load_s     = 1'b1;
                    timer_load_val_s = PULSE_LD;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PULSE: begin
                if (timer_expire_s) begin
                    next_state_s     = DEAD;
                    timer_load_s     = 1'b1;
                    timer_load_val_s = DEAD_LD;
                end else begin
                    next_state_s = PULSE;
                end
            end
            DEAD: begin
                if (timer_expire_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DEAD;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State, request capture and registered outputs. Drives lag the FSM by one
    // cycle, so q_exp/err updates are delayed to line up with the visible pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            req_val_r    <= 1'b0;
            pulse_done_r <= 1'b0;
            dead_done_r  <= 1'b0;
            s_out        <= 1'b0;
            r_out        <= 1'b0;
            req_ready    <= 1'b1;
            q_exp        <= 1'b0;
            q_known      <= 1'b0;
            err          <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            req_val_r    <= accept_s ? req_val : req_val_r;
            pulse_done_r <= (state_r == PULSE) && timer_expire_s;
            dead_done_r  <= (state_r == DEAD) && timer_expire_s;
            s_out        <= (state_r == PULSE) && req_val_r;
            r_out        <= (state_r == PULSE) && !req_val_r;
            req_ready    <= (next_state_s == IDLE);
            if (pulse_done_r) begin
                q_exp   <= req_val_r;
                q_known <= 1'b1;
            end else begin
                q_exp   <= q_exp;
                q_known <= q_known;
            end
            if (dead_done_r && (q_fb != q_exp)) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end else begin
                err <= err;
            end
        end
    end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench: cycle-index reference model, behavioural SR latch and
// directed plus randomized request streams.
module tb_sr_latch_driver;

    localparam int P = 4;
    localparam int D = 2;

    logic clk;
    logic rst;
    logic req_valid;
    logic req_val;
    logic req_ready;
    logic q_fb;
    logic err_clr;
    logic s_out;
    logic r_out;
    logic q_exp;
    logic q_known;
    logic err;

    int errors = 0;
    int checks = 0;
    int fb_mode = 0;  // 0 = real latch, 1 = stuck at 0, 2 = stuck at 1
    logic q_lat = 1'b0;

    // reference model state: edges counted since reset, start edge of last pulse
    int   n = 0;
    int   start = 0;
    bit   busy = 0;
    bit   tval = 0;
    bit   m_qexp = 0;
    bit   m_known = 0;
    bit   m_err = 0;

    sr_latch_driver #(.PULSE_W(P), .DEAD_W(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_val   (req_val),
        .req_ready (req_ready),
        .q_fb      (q_fb),
        .err_clr   (err_clr),
        .s_out     (s_out),
        .r_out     (r_out),
        .q_exp     (q_exp),
        .q_known   (q_known),
        .err       (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural latch with a small propagation delay after each clock edge
    initial begin
        q_fb = 1'b0;
        forever begin
            @(posedge clk or negedge clk or posedge rst);
            #1;
            if (s_out) q_lat = 1'b1;
            else if (r_out) q_lat = 1'b0;
            q_fb = (fb_mode == 1) ? 1'b0 : (fb_mode == 2) ? 1'b1 : q_lat;
        end
    end

    // reference model: a pulse started at edge k drives edges k+1..k+P,
    // updates q_exp at k+P+1, checks feedback at k+P+D+1
    initial begin
        bit rdy;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                n = 0; busy = 0; start = 0; tval = 0;
                m_qexp = 0; m_known = 0; m_err = 0;
            end else begin
                n++;
                if (busy && n == start + P + 1) begin
                    m_qexp = tval;
                    m_known = 1;
                end
                if (busy && n == start + P + D + 1 && q_fb != m_qexp) m_err = 1;
                else if (err_clr) m_err = 0;
                rdy = !busy || (n > start + P + D);
                if (rdy && req_valid && !(m_known && req_val == m_qexp)) begin
                    busy = 1;
                    start = n;
                    tval = req_val;
                end
            end
        end
    end

    // compare process plus pulse-width / dead-gap tracking
    initial begin
        bit prev_hi = 0;
        bit seen_fall = 0;
        int run = 0;
        int gap = 0;
        bit e_on;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_hi = 0; seen_fall = 0; run = 0; gap = 0;
            end else begin
                e_on = busy && (n >= start + 1) && (n <= start + P);
                chk("s_out", s_out, int'(e_on && tval));
                chk("r_out", r_out, int'(e_on && !tval));
                chk("req_ready", req_ready, int'(!busy || n >= start + P + D));
                chk("q_exp", q_exp, m_qexp);
                chk("q_known", q_known, m_known);
                chk("err", err, m_err);
                chk("s_and_r", s_out & r_out, 0);
                if ((s_out | r_out) && !prev_hi) begin
                    if (seen_fall) chk("dead_gap_ge_D", int'(gap >= D), 1);
                    run = 1;
                end else if (s_out | r_out) begin
                    run++;
                end else if (prev_hi) begin
                    chk("pulse_width", run, P);
                    seen_fall = 1;
                    gap = 1;
                end else begin
                    gap++;
                end
                prev_hi = s_out | r_out;
            end
        end
    end

    // waits for ready (bounded), presents one request for one cycle;
    // returns at the negedge following the handshake edge
    task automatic send(input logic v);
        int k;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) chk("ready_timeout", 0, 1);
        req_valid = 1'b1;
        req_val = v;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_val = 1'b0;
        err_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_out", s_out, 0);
        chk("rst_r_out", r_out, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_known", q_known, 0);
        chk("rst_err", err, 0);
        #1 rst = 1'b0;

        // set pulse: high after edges 1..4, q_exp at 5, ready at 6
        send(1'b1);
        chk("set_ready_low", req_ready, 0);
        chk("set_not_yet", s_out, 0);
        @(negedge clk);
        chk("set_first", s_out, 1);
        repeat (3) @(negedge clk);
        chk("set_last", s_out, 1);
        @(negedge clk);
        chk("set_fall", s_out, 0);
        chk("set_qexp", q_exp, 1);
        chk("set_known", q_known, 1);
        chk("set_dead_ready", req_ready, 0);
        @(negedge clk);
        chk("set_ready_back", req_ready, 1);
        @(negedge clk);
        chk("set_err", err, 0);

        // matching request absorbed, then reset pulse
        send(1'b1);
        chk("absorb_ready", req_ready, 1);
        @(negedge clk);
        chk("absorb_no_pulse", s_out, 0);
        send(1'b0);
        @(negedge clk);
        chk("clr_first", r_out, 1);
        repeat (3) @(negedge clk);
        chk("clr_last", r_out, 1);
        @(negedge clk);
        chk("clr_fall", r_out, 0);
        chk("clr_qexp", q_exp, 0);

        // back-to-back absorbed handshakes
        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        req_val = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("absorb_b2b_ready", req_ready, 1);
        end
        req_valid = 1'b0;

        // first request after reset is 0: still pulses
        do_reset();
        send(1'b0);
        @(negedge clk);
        chk("first_r_after_rst", r_out, 1);
        repeat (6) @(negedge clk);

        // stuck-at-0 latch: err at DEAD exit, then cleared
        fb_mode = 1;
        send(1'b1);
        repeat (6) @(negedge clk);
        chk("err_before_exit", err, 0);
        @(negedge clk);
        chk("err_set", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_cleared", err, 0);

        // mismatch coincident with err_clr: set wins
        fb_mode = 2;
        send(1'b0);
        repeat (6) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("err_set_wins", err, 1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        fb_mode = 0;

        // reset on the second pulse cycle
        send(1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pulse_on", s_out, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_s_out", s_out, 0);
        chk("midrst_r_out", r_out, 0);
        chk("midrst_ready", req_ready, 1);
        chk("midrst_known", q_known, 0);
        chk("midrst_qexp", q_exp, 0);
        chk("midrst_err", err, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        send(1'b1);
        @(negedge clk);
        chk("pulse_after_rst", s_out, 1);
        repeat (8) @(negedge clk);

        // randomized stream, inputs toggling regardless of ready
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            req_valid = 1'($urandom_range(0, 1));
            req_val = 1'($urandom_range(0, 1));
            err_clr = ($urandom_range(0, 15) == 0);
            fb_mode = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0;
        end
        @(negedge clk);
        req_valid = 1'b0;
        err_clr = 1'b0;
        fb_mode = 0;
        repeat (12) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
